rr_output_arbiter: RTL and testbench

Per-output-port wormhole arbiter for the 5-port mesh router. It collects head-flit requests from the five input ports that target one output, and picks a winner round-robin. It holds the winner for the whole packet until its tail flit transfers, then drives the one-hot grant vector that the output selector/crossbar mux consumes. One instance sits at each router output.

---
 rtl/rr_output_arbiter_pkg.sv | 18 +
 rtl/rr_output_arbiter_if.sv | 24 ++
 rtl/rr_pick.sv | 28 ++
 rtl/rr_output_arbiter.sv | 71 +++++++
 tb/tb_rr_output_arbiter.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/rr_output_arbiter_pkg.sv
// Shared constants and types for the per-output round-robin wormhole arbiter.
package rr_output_arbiter_pkg;

    localparam int unsigned NPORTS = 5;
    localparam int unsigned IDXW   = 3;

    localparam logic [IDXW-1:0] PORT_L = IDXW'(0);
    localparam logic [IDXW-1:0] PORT_N = IDXW'(1);
    localparam logic [IDXW-1:0] PORT_E = IDXW'(2);
    localparam logic [IDXW-1:0] PORT_S = IDXW'(3);
    localparam logic [IDXW-1:0] PORT_W = IDXW'(4);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage : rr_output_arbiter_pkg

// File: rtl/rr_output_arbiter_if.sv
// Request/flit-status inputs and grant outputs of one router output arbiter.
interface rr_output_arbiter_if;
    import rr_output_arbiter_pkg::*;

    logic [NPORTS-1:0] req;
    logic [NPORTS-1:0] valid;
    logic [NPORTS-1:0] tail;
    logic              credit_avail;
    logic [NPORTS-1:0] grant;
    logic [IDXW-1:0]   grant_idx;
    logic              xfer;
    logic              busy;

    modport master (
        output req, valid, tail, credit_avail,
        input  grant, grant_idx, xfer, busy
    );

    modport slave (
        input  req, valid, tail, credit_avail,
        output grant, grant_idx, xfer, busy
    );

endinterface : rr_output_arbiter_if

// File: rtl/rr_pick.sv
// Rotating priority select: first set request bit after i_ptr, wrapping modulo NPORTS.
module rr_pick #(
    parameter int unsigned NPORTS = 5,
    parameter int unsigned IDXW   = 3
) (
    input  logic [NPORTS-1:0] i_req,
    input  logic [IDXW-1:0]   i_ptr,
    output logic              o_found,
    output logic [IDXW-1:0]   o_idx
);

    int unsigned w_cand;

    // Candidate order is ptr+1 .. ptr+NPORTS, so the last winner is checked last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = 0;
        for (int unsigned k = 1; k <= NPORTS; k++) begin
            w_cand = (int'(i_ptr) + k) % NPORTS;
            if (!o_found && i_req[IDXW'(w_cand)]) begin
                o_found = 1'b1;
                o_idx   = IDXW'(w_cand);
            end
        end
    end

endmodule : rr_pick

// File: rtl/rr_output_arbiter.sv
// Wormhole output arbiter: round-robin pick in IDLE, grant locked until the winner's tail transfers.
module rr_output_arbiter
    import rr_output_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    rr_output_arbiter_if.slave   bus
);

    state_e            r_state;
    logic [IDXW-1:0]   r_ptr;
    logic [NPORTS-1:0] r_grant;
    logic [IDXW-1:0]   r_grant_idx;
    logic              r_busy;

    logic              w_found;
    logic [IDXW-1:0]   w_win;
    logic              w_xfer;
    logic              w_tail_xfer;

    rr_pick #(
        .NPORTS (NPORTS),
        .IDXW   (IDXW)
    ) u_pick (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_win)
    );

    // grant is zero outside LOCKED, so these are inherently gated by state.
    assign w_xfer      = (|(r_grant & bus.valid)) & bus.credit_avail;
    assign w_tail_xfer = (|(r_grant & bus.valid & bus.tail)) & bus.credit_avail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= IDXW'(NPORTS - 1);
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state     <= LOCKED;
                        r_grant     <= NPORTS'(1) << w_win;
                        r_grant_idx <= w_win;
                        r_busy      <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (w_tail_xfer) begin
                        r_state     <= IDLE;
                        r_ptr       <= r_grant_idx;
                        r_grant     <= '0;
                        r_grant_idx <= '0;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.grant     = r_grant;
    assign bus.grant_idx = r_grant_idx;
    assign bus.busy      = r_busy;
    assign bus.xfer      = w_xfer;

endmodule : rr_output_arbiter

// File: tb/tb_rr_output_arbiter.sv
// Directed bench for rr_output_arbiter with an expected-winner scoreboard and per-cycle grant invariants.
module tb_rr_output_arbiter;
    import rr_output_arbiter_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   exp_q[$];

    rr_output_arbiter_if bus();

    rr_output_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NPORTS-1:0] onehot(input int p);
        logic [NPORTS-1:0] v;
        v = NPORTS'(1) << p;
        return v;
    endfunction

    // Grant shape and index consistency, independent of stimulus.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [31:0] exp_idx;
            exp_idx = 0;
            for (int i = 0; i < NPORTS; i++)
                if (bus.grant[i]) exp_idx = i;
            chk("inv_onehot0", 32'($onehot0(bus.grant)), 1);
            chk("inv_idx", 32'(bus.grant_idx), exp_idx);
            chk("inv_busy", 32'(bus.busy), 32'(bus.grant != '0));
            if (bus.grant == '0) chk("inv_xfer_idle", 32'(bus.xfer), 0);
        end
    end

    task automatic drive(input logic [NPORTS-1:0] r, input logic [NPORTS-1:0] v,
                         input logic [NPORTS-1:0] t, input logic c);
        bus.req          = r;
        bus.valid        = v;
        bus.tail         = t;
        bus.credit_avail = c;
    endtask

    // Wait (bounded) for a grant and compare it with the oldest scoreboard entry.
    task automatic wait_grant(input string tag);
        int cyc;
        int e;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.grant == '0 && cyc < 20);
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 0;
        chk({tag, "_latency"}, cyc, 1);
        chk({tag, "_grant"}, 32'(bus.grant), 32'(onehot(e)));
        chk({tag, "_idx"}, 32'(bus.grant_idx), e);
        chk({tag, "_busy"}, 32'(bus.busy), 1);
    endtask

    // One cycle of flit activity while locked; grant must still be held afterwards.
    task automatic step(input string tag, input logic [NPORTS-1:0] v, input logic [NPORTS-1:0] t,
                        input logic c, input logic exp_xfer, input int held);
        bus.valid        = v;
        bus.tail         = t;
        bus.credit_avail = c;
        #1;
        chk({tag, "_xfer"}, 32'(bus.xfer), 32'(exp_xfer));
        @(negedge clk);
        chk({tag, "_held"}, 32'(bus.grant), 32'(onehot(held)));
    endtask

    // Tail transfer on the granted port; release must follow on the next edge.
    task automatic send_tail(input string tag, input int port, input logic [NPORTS-1:0] next_req);
        bus.valid        = onehot(port);
        bus.tail         = onehot(port);
        bus.credit_avail = 1'b1;
        #1;
        chk({tag, "_tail_xfer"}, 32'(bus.xfer), 1);
        @(negedge clk);
        chk({tag, "_rel_grant"}, 32'(bus.grant), 0);
        chk({tag, "_rel_idx"}, 32'(bus.grant_idx), 0);
        chk({tag, "_rel_busy"}, 32'(bus.busy), 0);
        bus.valid = '0;
        bus.tail  = '0;
        bus.req   = next_req;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive('0, '0, '0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_idx", 32'(bus.grant_idx), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_xfer", 32'(bus.xfer), 0);
        rst_n = 1'b1;

        // Basic pick from reset pointer, then rotation past the last winner.
        bus.req = 5'b00101;
        exp_q.push_back(int'(PORT_L));
        wait_grant("t1a");
        send_tail("t1a", int'(PORT_L), 5'b00101);
        exp_q.push_back(int'(PORT_E));
        wait_grant("t1b");
        send_tail("t1b", int'(PORT_E), '0);

        // Full contention with single-flit packets from a fresh pointer.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.req = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(k % NPORTS);
            wait_grant($sformatf("t2_%0d", k));
            send_tail($sformatf("t2_%0d", k), k % NPORTS, (k == 5) ? 5'b00000 : 5'b11111);
        end

        // Four-flit packet on port 2 with credit stalls and foreign tail noise.
        @(negedge clk);
        bus.req = onehot(int'(PORT_E));
        exp_q.push_back(int'(PORT_E));
        wait_grant("t3");
        step("t3_f1", 5'b00100, 5'b00000, 1'b1, 1'b1, 2);
        step("t3_nc1", 5'b00110, 5'b00010, 1'b0, 1'b0, 2);
        step("t3_nc2", 5'b00100, 5'b00000, 1'b0, 1'b0, 2);
        step("t3_f2", 5'b00100, 5'b00000, 1'b1, 1'b1, 2);
        step("t3_f3", 5'b00110, 5'b00010, 1'b1, 1'b1, 2);
        step("t3_tail_nc", 5'b00100, 5'b00100, 1'b0, 1'b0, 2);
        send_tail("t3", int'(PORT_E), '0);

        // Lock on port 3 survives request changes; port 1 wins afterwards.
        @(negedge clk);
        bus.req = onehot(int'(PORT_S));
        exp_q.push_back(int'(PORT_S));
        wait_grant("t4a");
        bus.req = onehot(int'(PORT_N));
        step("t4_rq1", 5'b00000, 5'b00000, 1'b1, 1'b0, 3);
        step("t4_rq2", 5'b00010, 5'b00010, 1'b1, 1'b0, 3);
        send_tail("t4a", int'(PORT_S), onehot(int'(PORT_N)));
        exp_q.push_back(int'(PORT_N));
        wait_grant("t4b");
        send_tail("t4b", int'(PORT_N), '0);

        // Asynchronous reset in the middle of a packet on port 4.
        @(negedge clk);
        bus.req = onehot(int'(PORT_W));
        exp_q.push_back(int'(PORT_W));
        wait_grant("t5a");
        step("t5_f1", 5'b10000, 5'b00000, 1'b1, 1'b1, 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_grant", 32'(bus.grant), 0);
        chk("t5_async_busy", 32'(bus.busy), 0);
        chk("t5_async_idx", 32'(bus.grant_idx), 0);
        chk("t5_async_xfer", 32'(bus.xfer), 0);
        drive(5'b10001, '0, '0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(int'(PORT_L));
        wait_grant("t5b");
        send_tail("t5b", int'(PORT_L), '0);

        @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_rr_output_arbiter
